vend_change_dispenser: RTL and testbench

- Payout end of the vending flow: the vending FSM reports change owed; this block pays it out as physical coins.
- Takes an amount in 5-cent units and drives a two-tube coin hopper (10c tube, 5c tube) with a four-phase eject/ack handshake.
- Greedy payout: a 10c coin is preferred, with 5c as fallback.
- Reports completion, shortfall fault, and the un-dispensed remainder.

---
 rtl/vend_pkg.sv | 23 ++
 rtl/vend_ack_timer.sv | 39 +++
 rtl/vend_change_dispenser.sv | 117 +++++++++++
 tb/tb_vend_change_dispenser.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending datapath: coin codes, denominations in
// 5-cent units, and the change dispenser state encoding.
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_5    = 2'b01,
        COIN_10   = 2'b10
    } coin_e;

    localparam int D5  = 1;
    localparam int D10 = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_RELEASE,
        ST_DONE,
        ST_FAULT
    } disp_state_e;

endpackage

// File: rtl/vend_ack_timer.sv
// Clear/enable cycle counter with a flag raised on the cycle whose increment
// reaches TIMEOUT; shared by the change dispenser and the coin acceptor.
module vend_ack_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flag is asserted while counting so the owner can leave on the TIMEOUT-th cycle.
    assign hit_o = en_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/vend_change_dispenser.sv
// Pays out change owed (5-cent units) through a two-tube hopper, preferring
// 10c coins, with a four-phase eject/ack handshake and an ack timeout.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W   = 3,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             hop10_empty,
    input  logic             hop5_empty,
    input  logic             hop_ack,
    output logic             eject10,
    output logic             eject5,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining
);

    disp_state_e      state_q, state_d;
    coin_e            coin_q, coin_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0] coin_val;
    logic             eject10_q, eject5_q, busy_q, done_q, fault_q;
    logic             tmr_hit;

    vend_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk   (clk),
        .reset (reset),
        .clr_i (state_q != ST_EJECT),
        .en_i  (state_q == ST_EJECT),
        .hit_o (tmr_hit)
    );

    assign coin_val = (coin_q == COIN_10) ? AMT_W'(D10) : AMT_W'(D5);

    always_comb begin
        state_d = state_q;
        coin_d  = coin_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d   = amount;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                // Tube levels are only trusted here; a tube emptying mid-coin is caught next pass.
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else if ((rem_q >= AMT_W'(D10)) && !hop10_empty) begin
                    coin_d  = COIN_10;
                    state_d = ST_EJECT;
                end else if (!hop5_empty) begin
                    coin_d  = COIN_5;
                    state_d = ST_EJECT;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            ST_EJECT: begin
                if (hop_ack) begin
                    rem_d   = rem_q - coin_val;
                    state_d = ST_RELEASE;
                end else if (tmr_hit) begin
                    state_d = ST_FAULT;
                end
            end
            ST_RELEASE: begin
                if (!hop_ack) begin
                    state_d = ST_SELECT;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Eject/done/fault follow the state one cycle later; busy tracks the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            coin_q    <= COIN_NONE;
            rem_q     <= '0;
            eject10_q <= 1'b0;
            eject5_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            coin_q    <= coin_d;
            rem_q     <= rem_d;
            eject10_q <= (state_q == ST_EJECT) && (coin_q == COIN_10);
            eject5_q  <= (state_q == ST_EJECT) && (coin_q == COIN_5);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_q == ST_DONE) || (state_q == ST_FAULT);
            fault_q   <= (state_q == ST_FAULT);
        end
    end

    assign eject10   = eject10_q;
    assign eject5    = eject5_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Randomized and directed bench for vend_change_dispenser with a behavioural
// hopper and a greedy-payout reference model.
module tb_vend_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] amount;
    logic       hop10_empty;
    logic       hop5_empty;
    logic       hop_ack = 1'b0;
    logic       eject10, eject5, busy, done, fault;
    logic [2:0] remaining;

    int n_checks = 0;
    int n_fail   = 0;

    // Hopper behaviour knobs (written by the test sequence only).
    bit hop_on  = 1'b0;
    int ack_dly = 2;
    int rel_dly = 0;

    // Observation logs (written by the monitor only).
    int         coin_log[$];
    int         rem_log[$];
    int         n_done = 0;
    int         n_both = 0;
    logic [2:0] last_rem = 3'd0;

    int exp_coins[$];

    vend_change_dispenser #(
        .AMT_W   (3),
        .TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .amount      (amount),
        .hop10_empty (hop10_empty),
        .hop5_empty  (hop5_empty),
        .hop_ack     (hop_ack),
        .eject10     (eject10),
        .eject5      (eject5),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .remaining   (remaining)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor plus hopper: logs coin starts, done pulses and remaining changes,
    // and answers each eject with an ack after ack_dly cycles.
    initial begin
        bit p10, p5;
        int wcnt, rcnt;
        p10 = 1'b0; p5 = 1'b0; wcnt = 0; rcnt = 0;
        forever begin
            @(negedge clk);
            if (eject10 && !p10) coin_log.push_back(10);
            if (eject5 && !p5) coin_log.push_back(5);
            p10 = eject10;
            p5  = eject5;
            if (eject10 && eject5) n_both++;
            if (done) n_done++;
            if (remaining != last_rem) begin
                rem_log.push_back(int'(remaining));
                last_rem = remaining;
            end
            if (!hop_on) begin
                hop_ack = 1'b0; wcnt = 0; rcnt = 0;
            end else if (hop_ack) begin
                if (!eject10 && !eject5) begin
                    if (rcnt >= rel_dly) begin
                        hop_ack = 1'b0; rcnt = 0;
                    end else begin
                        rcnt++;
                    end
                end
            end else if (eject10 || eject5) begin
                if (wcnt >= ack_dly) begin
                    hop_ack = 1'b1; wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Greedy payout from plain arithmetic: tens first, then fives; returns what is left unpaid.
    function automatic int model_payout(input int amt, input bit e10, input bit e5);
        int n10, n5, r;
        n10 = e10 ? 0 : amt / 2;
        r   = amt - 2 * n10;
        n5  = e5 ? 0 : r;
        exp_coins.delete();
        repeat (n10) exp_coins.push_back(10);
        repeat (n5) exp_coins.push_back(5);
        return r - n5;
    endfunction

    // Caller is at a negedge; start is sampled by the following posedge.
    task automatic do_start(input logic [2:0] amt);
        amount = amt;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got, output bit flt);
        got = 1'b0;
        flt = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                flt = fault;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; amount = 3'd0;
        hop10_empty = 1'b0; hop5_empty = 1'b0; hop_on = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({eject10, eject5, busy, done, fault, remaining} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {eject10, eject5, busy, done, fault, remaining});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_change3();
        int base, rbase;
        bit got, flt;
        hop_on = 1'b1; ack_dly = 2; rel_dly = 0;
        hop10_empty = 1'b0; hop5_empty = 1'b0;
        base = coin_log.size(); rbase = rem_log.size();
        do_start(3'd3);
        n_checks++;
        if (busy !== 1'b1 || eject10 !== 1'b0) begin
            n_fail++;
            $display("FAIL c3_k: busy=%b eject10=%b required 1 0", busy, eject10);
        end
        @(negedge clk);
        n_checks++;
        if (eject10 !== 1'b0) begin
            n_fail++;
            $display("FAIL c3_k1_eject: got %b required 0", eject10);
        end
        @(negedge clk);
        n_checks++;
        if (eject10 !== 1'b1 || eject5 !== 1'b0) begin
            n_fail++;
            $display("FAIL c3_k2_eject: eject10=%b eject5=%b required 1 0", eject10, eject5);
        end
        wait_done(100, got, flt);
        n_checks++;
        if (!got || flt !== 1'b0 || remaining !== 3'd0) begin
            n_fail++;
            $display("FAIL c3_done: done=%b fault=%b rem=%0d required 1 0 0", got, flt, remaining);
        end
        n_checks++;
        if (coin_log.size() - base != 2 || coin_log[base] != 10 || coin_log[base+1] != 5) begin
            n_fail++;
            $display("FAIL c3_coins: count=%0d required 2 coins 10 then 5", coin_log.size() - base);
        end
        n_checks++;
        if (rem_log.size() - rbase != 3 || rem_log[rbase] != 3 || rem_log[rbase+1] != 1 ||
            rem_log[rbase+2] != 0) begin
            n_fail++;
            $display("FAIL c3_rem_trace: entries=%0d required 3 1 0", rem_log.size() - rbase);
        end
    endtask

    task automatic test_no10();
        int base;
        bit got, flt, ok;
        hop_on = 1'b1; ack_dly = 1; rel_dly = 0;
        hop10_empty = 1'b1; hop5_empty = 1'b0;
        base = coin_log.size();
        do_start(3'd4);
        wait_done(150, got, flt);
        n_checks++;
        if (!got || flt !== 1'b0 || remaining !== 3'd0) begin
            n_fail++;
            $display("FAIL no10_done: done=%b fault=%b rem=%0d required 1 0 0", got, flt, remaining);
        end
        ok = (coin_log.size() - base == 4);
        for (int i = base; i < coin_log.size(); i++) if (coin_log[i] != 5) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL no10_coins: got %0d coins required four 5c only", coin_log.size() - base);
        end
        hop10_empty = 1'b0;
    endtask

    task automatic test_zero();
        int base;
        base = coin_log.size();
        do_start(3'd0);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_k: busy=%b done=%b required 1 0", busy, done);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_k1: busy=%b done=%b required 1 0", busy, done);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || fault !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_k2: done=%b fault=%b busy=%b required 1 0 0", done, fault, busy);
        end
        n_checks++;
        if (coin_log.size() != base) begin
            n_fail++;
            $display("FAIL zero_no_eject: got %0d coins required 0", coin_log.size() - base);
        end
    endtask

    task automatic test_empty();
        int base;
        bit got, flt;
        hop10_empty = 1'b1; hop5_empty = 1'b1;
        base = coin_log.size();
        do_start(3'd2);
        wait_done(20, got, flt);
        n_checks++;
        if (!got || flt !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_fault: done=%b fault=%b required 1 1", got, flt);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (remaining !== 3'd2 || busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0 ||
            coin_log.size() != base) begin
            n_fail++;
            $display("FAIL empty_hold: rem=%0d busy=%b done=%b fault=%b required 2 0 0 0",
                     remaining, busy, done, fault);
        end
        hop10_empty = 1'b0; hop5_empty = 1'b0;
    endtask

    task automatic test_timeout();
        int cnt;
        bit got, flt;
        hop_on = 1'b0;
        hop10_empty = 1'b0; hop5_empty = 1'b0;
        cnt = 0; got = 1'b0; flt = 1'b0;
        do_start(3'd1);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1; flt = fault;
                break;
            end
            if (eject5) cnt++;
        end
        n_checks++;
        if (cnt != 15) begin
            n_fail++;
            $display("FAIL timeout_len: eject5 high %0d cycles required 15", cnt);
        end
        n_checks++;
        if (!got || flt !== 1'b1 || remaining !== 3'd1 || eject5 !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fault: done=%b fault=%b rem=%0d eject5=%b required 1 1 1 0",
                     got, flt, remaining, eject5);
        end
    endtask

    task automatic test_reset_mid();
        int dbase;
        bit seen;
        hop_on = 1'b0;
        seen = 1'b0;
        do_start(3'd3);
        for (int c = 0; c < 10; c++) begin
            if (eject10) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rst_mid_reach: eject10 never seen required 1");
        end
        dbase = n_done;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({eject10, eject5, busy, done, fault, remaining} !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %b required 00000000",
                     {eject10, eject5, busy, done, fault, remaining});
        end
        reset = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (n_done != dbase || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_nodone: done pulses=%0d busy=%b required 0 0", n_done - dbase, busy);
        end
    endtask

    task automatic test_start_in_release();
        int base, dbase;
        bit seen, got, flt;
        hop_on = 1'b1; ack_dly = 1; rel_dly = 3;
        hop10_empty = 1'b0; hop5_empty = 1'b0;
        base = coin_log.size(); dbase = n_done; seen = 1'b0;
        do_start(3'd3);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (hop_ack && !eject10 && !eject5) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rel_reach: release phase not seen required 1");
        end
        do_start(3'd7);
        wait_done(100, got, flt);
        repeat (10) @(negedge clk);
        n_checks++;
        if (!got || flt !== 1'b0 || remaining !== 3'd0 || n_done - dbase != 1) begin
            n_fail++;
            $display("FAIL rel_start_ignored: done=%b fault=%b rem=%0d pulses=%0d required 1 0 0 1",
                     got, flt, remaining, n_done - dbase);
        end
        n_checks++;
        if (coin_log.size() - base != 2 || coin_log[base] != 10 || coin_log[base+1] != 5) begin
            n_fail++;
            $display("FAIL rel_coins: count=%0d required 2 coins 10 then 5", coin_log.size() - base);
        end
        rel_dly = 0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int amt, base, left;
            bit e10, e5, got, flt, ok;
            amt = int'($urandom_range(0, 7));
            e10 = ($urandom_range(0, 3) == 0);
            e5  = ($urandom_range(0, 3) == 0);
            ack_dly = int'($urandom_range(0, 4));
            rel_dly = int'($urandom_range(0, 2));
            hop_on = 1'b1;
            hop10_empty = e10; hop5_empty = e5;
            left = model_payout(amt, e10, e5);
            base = coin_log.size();
            do_start(3'(amt));
            wait_done(250, got, flt);
            n_checks++;
            if (!got || flt !== (left != 0) || int'(remaining) != left) begin
                n_fail++;
                $display("FAIL rand_%0d_result: amt=%0d e10=%b e5=%b done=%b fault=%b rem=%0d required 1 %b %0d",
                         it, amt, e10, e5, got, flt, remaining, (left != 0), left);
            end
            ok = (coin_log.size() - base == exp_coins.size());
            if (ok) for (int i = 0; i < exp_coins.size(); i++) if (coin_log[base+i] != exp_coins[i]) ok = 1'b0;
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rand_%0d_coins: amt=%0d got %0d coins required %0d", it, amt,
                         coin_log.size() - base, exp_coins.size());
            end
        end
        n_checks++;
        if (n_both != 0) begin
            n_fail++;
            $display("FAIL both_ejects: cycles with both ejects=%0d required 0", n_both);
        end
    endtask

    initial begin
        test_reset();
        test_change3();
        test_no10();
        test_zero();
        test_empty();
        test_timeout();
        test_reset_mid();
        test_start_in_release();
        test_random();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
